// File: rtl/specialized_multiplier_inverse_if.sv
// Stream bundle for the specialized-multiplier inverse decoder:
// seven-segment input stream, recovered-operand output stream, statistics.
interface specialized_multiplier_inverse_if #(
  parameter int CNT_W = 8
);
  logic [6:0]       SEG_IN;
  logic             IN_VALID;
  logic             IN_READY;
  logic [3:0]       OUT;
  logic             AMBIG;
  logic             ERR;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [CNT_W-1:0] DEC_CNT;
  logic [CNT_W-1:0] ERR_CNT;

  // Decoder side
  modport slave (
    input  SEG_IN, IN_VALID, OUT_READY,
    output IN_READY, OUT, AMBIG, ERR, OUT_VALID, DEC_CNT, ERR_CNT
  );

  // Producer/consumer side
  modport master (
    output SEG_IN, IN_VALID, OUT_READY,
    input  IN_READY, OUT, AMBIG, ERR, OUT_VALID, DEC_CNT, ERR_CNT
  );
endinterface

// File: rtl/specialized_multiplier_inverse.sv
// Receive end of the specialized-multiplier display link.
// S1 captures the active-low segment pattern, S2 holds the recovered operand
// with ambiguity/illegal flags. Elastic two-stage pipe, one transfer per cycle.
module specialized_multiplier_inverse #(
  parameter int CNT_W = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  specialized_multiplier_inverse_if.slave  io_bus
);

  logic             r_s1_v;
  logic [6:0]       r_s1_seg;
  logic             r_s2_v;
  logic [3:0]       r_out;
  logic             r_ambig;
  logic             r_err;
  logic [CNT_W-1:0] r_dec_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_out_xfer;
  logic             w_s2_load;
  logic             w_in_ready;
  logic             w_in_xfer;
  logic [3:0]       w_dec_out;
  logic             w_dec_ambig;
  logic             w_dec_err;

  assign w_out_xfer = r_s2_v & io_bus.OUT_READY;
  assign w_s2_load  = !r_s2_v | w_out_xfer;
  assign w_in_ready = i_rst_n & (!r_s1_v | w_s2_load);
  assign w_in_xfer  = io_bus.IN_VALID & w_in_ready;

  // Pattern -> operand. Only codes the multiplier can emit are legal; for codes
  // reached by several operands the smallest is reported with AMBIG set.
  always_comb begin
    w_dec_out   = 4'd0;
    w_dec_ambig = 1'b0;
    w_dec_err   = 1'b0;
    case (r_s1_seg)
      7'b1000000: begin w_dec_out = 4'd0; w_dec_ambig = 1'b1; end // '0': 0, 9..15
      7'b1111001: w_dec_out = 4'd1;                               // '1'
      7'b0100100: w_dec_out = 4'd2;                               // '2'
      7'b1111000: w_dec_out = 4'd3;                               // '7' = 2*3+1
      7'b0010000: w_dec_out = 4'd4;                               // '9' = 2*4+1
      7'b0000011: begin w_dec_out = 4'd5; w_dec_ambig = 1'b1; end // 'b': 5 or 6
      7'b0100001: w_dec_out = 4'd7;                               // 'd' = 2*7-1
      7'b0001110: w_dec_out = 4'd8;                               // 'F' = 2*8-1
      default:    w_dec_err = 1'b1;
    endcase
  end

  // Pipeline stages: S1 refills on accept or drains into S2; S2 holds under backpressure.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_v   <= 1'b0;
      r_s1_seg <= 7'd0;
      r_s2_v   <= 1'b0;
      r_out    <= 4'd0;
      r_ambig  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_in_xfer) begin
        r_s1_v   <= 1'b1;
        r_s1_seg <= io_bus.SEG_IN;
      end else if (w_s2_load) begin
        r_s1_v   <= 1'b0;
      end
      if (w_s2_load) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) begin
          r_out   <= w_dec_out;
          r_ambig <= w_dec_ambig;
          r_err   <= w_dec_err;
        end
      end
    end
  end

  // Saturating statistics, advanced only by completed output transfers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_dec_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_out_xfer) begin
      if (r_dec_cnt != '1)          r_dec_cnt <= r_dec_cnt + 1'b1;
      if (r_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign io_bus.IN_READY  = w_in_ready;
  assign io_bus.OUT       = r_out;
  assign io_bus.AMBIG     = r_ambig;
  assign io_bus.ERR       = r_err;
  assign io_bus.OUT_VALID = r_s2_v;
  assign io_bus.DEC_CNT   = r_dec_cnt;
  assign io_bus.ERR_CNT   = r_err_cnt;

endmodule

// File: tb/tb_specialized_multiplier_inverse.sv
// Bench for specialized_multiplier_inverse: directed steps plus a random phase,
// scored against a model built from the hex font and the multiply map.
module tb_specialized_multiplier_inverse;

  typedef struct {
    logic [3:0] op;
    logic       ambig;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  specialized_multiplier_inverse_if #(.CNT_W(8)) bus ();
  specialized_multiplier_inverse_if #(.CNT_W(2)) bus2 ();

  // Narrow-counter twin sees exactly the same stream.
  assign bus2.SEG_IN    = bus.SEG_IN;
  assign bus2.IN_VALID  = bus.IN_VALID;
  assign bus2.OUT_READY = bus.OUT_READY;

  specialized_multiplier_inverse #(.CNT_W(8)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus));
  specialized_multiplier_inverse #(.CNT_W(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus2));

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  int   exp_dec = 0;
  int   exp_err = 0;
  logic last_ix;
  logic [6:0] legal [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b1111000,
                            7'b0010000, 7'b0000011, 7'b0100001, 7'b0001110};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Standard active-low hex font, bit6=g .. bit0=a.
  function automatic logic [6:0] font(input int d);
    case (d)
      0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;
      3: return 7'b0110000;   4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;   8: return 7'b0000000;
      9: return 7'b0010000;  10: return 7'b0001000;  11: return 7'b0000011;
     12: return 7'b1000110;  13: return 7'b0100001;  14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic int mulmap(input int x);
    if (x <= 2) return x;
    if (x <= 5) return 2*x + 1;
    if (x <= 8) return 2*x - 1;
    return 0;
  endfunction

  // Invert by search: which digit is shown, and which operands produce it.
  function automatic exp_t model(input logic [6:0] seg);
    exp_t e;
    int dig = -1;
    int n = 0;
    e.op = 4'd0; e.ambig = 1'b0; e.err = 1'b1;
    for (int d = 0; d < 16; d++) if (font(d) == seg) dig = d;
    if (dig >= 0)
      for (int x = 15; x >= 0; x--)
        if (mulmap(x) == dig) begin n++; e.op = 4'(x); end
    if (n > 0) begin e.err = 1'b0; e.ambig = (n > 1); end
    else e.op = 4'd0;
    return e;
  endfunction

  // One clock: settle inputs, score handshakes, cross the edge, return at negedge.
  task automatic tick();
    logic ix, ox;
    exp_t e;
    #1;
    ix = 1'b0;
    if (!rst_n) begin
      chk("rst_in_ready", 32'(bus.IN_READY), 32'd0);
    end else begin
      ix = bus.IN_VALID & bus.IN_READY;
      ox = bus.OUT_VALID & bus.OUT_READY;
      chk("dec_cnt", 32'(bus.DEC_CNT), 32'(exp_dec));
      chk("err_cnt", 32'(bus.ERR_CNT), 32'(exp_err));
      chk("dec_cnt_w2", 32'(bus2.DEC_CNT), 32'(exp_dec > 3 ? 3 : exp_dec));
      chk("err_cnt_w2", 32'(bus2.ERR_CNT), 32'(exp_err > 3 ? 3 : exp_err));
      if (ox) begin
        if (q.size() == 0) chk("spurious_out", 32'(bus.OUT_VALID), 32'd0);
        else begin
          e = q.pop_front();
          chk("out",   32'(bus.OUT),   32'(e.op));
          chk("ambig", 32'(bus.AMBIG), 32'(e.ambig));
          chk("err",   32'(bus.ERR),   32'(e.err));
          if (exp_dec < 255) exp_dec++;
          if (e.err && exp_err < 255) exp_err++;
        end
      end
      if (ix) q.push_back(model(bus.SEG_IN));
    end
    last_ix = ix;
    @(posedge clk);
    if (!rst_n) begin q.delete(); exp_dec = 0; exp_err = 0; end
    @(negedge clk);
  endtask

  initial begin
    int k;
    logic [5:0] hold;
    logic have_hold;
    logic [6:0] pats [3] = '{7'b1111001, 7'b0100100, 7'b1111000};

    // Reset held with traffic offered
    rst_n = 1'b0; bus.IN_VALID = 1'b1; bus.SEG_IN = 7'b1000000; bus.OUT_READY = 1'b0;
    @(negedge clk);
    tick(); tick();
    chk("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("rst_dec_cnt", 32'(bus.DEC_CNT), 32'd0);
    chk("rst_err_cnt", 32'(bus.ERR_CNT), 32'd0);
    chk("rst_in_ready_hold", 32'(bus.IN_READY), 32'd0);
    rst_n = 1'b1;

    // All legal patterns streamed back to back
    bus.OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.SEG_IN = legal[i];
      tick();
      if (i == 0) chk("lat_not_yet", 32'(bus.OUT_VALID), 32'd0);
      if (i == 1) chk("lat_valid", 32'(bus.OUT_VALID), 32'd1);
    end
    bus.IN_VALID = 1'b0;
    repeat (3) tick();
    chk("dec_cnt_8", 32'(bus.DEC_CNT), 32'd8);

    // Illegal codes
    bus.IN_VALID = 1'b1;
    bus.SEG_IN = 7'b0000110; tick();
    bus.SEG_IN = 7'b1111111; tick();
    bus.IN_VALID = 1'b0;
    repeat (3) tick();
    chk("err_cnt_2", 32'(bus.ERR_CNT), 32'd2);

    // Backpressure: 5 stalled cycles offering 3 patterns
    bus.OUT_READY = 1'b0; bus.IN_VALID = 1'b1; k = 0; have_hold = 1'b0; hold = '0;
    for (int c = 0; c < 5; c++) begin
      bus.SEG_IN = pats[k > 2 ? 2 : k];
      tick();
      if (last_ix) k++;
      if (bus.OUT_VALID) begin
        if (have_hold) chk("s2_stable", 32'({bus.OUT, bus.AMBIG, bus.ERR}), 32'(hold));
        else begin hold = {bus.OUT, bus.AMBIG, bus.ERR}; have_hold = 1'b1; end
      end
    end
    chk("stall_accepted", 32'(k), 32'd2);
    chk("stall_in_ready", 32'(bus.IN_READY), 32'd0);
    bus.OUT_READY = 1'b1;
    for (int c = 0; c < 20 && k < 3; c++) begin
      bus.SEG_IN = pats[k > 2 ? 2 : k];
      tick();
      if (last_ix) k++;
    end
    chk("stall_all_sent", 32'(k), 32'd3);
    bus.IN_VALID = 1'b0;
    repeat (4) tick();
    chk("stall_drained", 32'(q.size()), 32'd0);
    chk("w2_saturated", 32'(bus2.DEC_CNT), 32'd3);

    // Reset with both stages full
    bus.OUT_READY = 1'b0; bus.IN_VALID = 1'b1;
    bus.SEG_IN = 7'b1111000; tick();
    bus.SEG_IN = 7'b0100001; tick();
    tick();
    chk("full_out_valid", 32'(bus.OUT_VALID), 32'd1);
    chk("full_in_ready", 32'(bus.IN_READY), 32'd0);
    rst_n = 1'b0; bus.IN_VALID = 1'b0;
    tick();
    chk("flush_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("flush_out", 32'(bus.OUT), 32'd0);
    chk("flush_dec_cnt", 32'(bus.DEC_CNT), 32'd0);
    rst_n = 1'b1; bus.OUT_READY = 1'b1;
    repeat (4) tick();
    chk("flush_no_ghost", 32'(bus.OUT_VALID), 32'd0);

    // Random traffic, long enough to saturate the 8-bit counters
    for (int c = 0; c < 700; c++) begin
      bus.IN_VALID  = ($urandom_range(0, 3) != 0);
      bus.OUT_READY = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       bus.SEG_IN = legal[$urandom_range(0, 7)];
        1:       bus.SEG_IN = font(int'($urandom_range(0, 15)));
        default: bus.SEG_IN = 7'($urandom);
      endcase
      tick();
    end
    bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b1;
    repeat (4) tick();
    chk("rand_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
